// File: rtl/bus_pkg.sv
// Shared memory map, region and state types for the 68000 bus controller.
// The mmu uses the same region constants so both blocks agree on the map.
package bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_ROM,
        REG_GFX,
        REG_IO,
        REG_NONE
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XLATE,
        ST_WAIT,
        ST_ACK,
        ST_BERR,
        ST_AUTOVEC
    } state_t;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam logic [15:0] RAM_BASE = 16'h8000;
    localparam logic [15:0] RAM_MASK = 16'h8000;
    localparam logic [15:0] ROM_BASE = 16'h4000;
    localparam logic [15:0] ROM_MASK = 16'hC000;
    localparam logic [15:0] GFX_BASE = 16'h3C00;
    localparam logic [15:0] GFX_MASK = 16'hFC00;
    localparam logic [15:0] IO_BASE  = 16'h0300;
    localparam logic [15:0] IO_MASK  = 16'hFF00;

    function automatic logic in_region(
        input logic [15:0] page,
        input logic [15:0] base,
        input logic [15:0] mask
    );
        return (page & mask) == base;
    endfunction

    // Active-low selects, ordered {ram, rom, gfx, io}.
    function automatic logic [3:0] region_cs(input region_t r);
        logic [3:0] cs;
        cs = 4'b1111;
        case (r)
            REG_RAM: cs = 4'b0111;
            REG_ROM: cs = 4'b1011;
            REG_GFX: cs = 4'b1101;
            REG_IO:  cs = 4'b1110;
            default: cs = 4'b1111;
        endcase
        return cs;
    endfunction

endpackage

// File: rtl/phys_decode.sv
// Physical page to region decode.
// The regions are disjoint, so the priority order never has to arbitrate.
module phys_decode
    import bus_pkg::*;
(
    input  logic [15:0] phys_page,
    output region_t     region
);

    // Match the page against each region window of the memory map.
    always_comb begin
        region = REG_NONE;
        unique case (1'b1)
            in_region(phys_page, RAM_BASE, RAM_MASK): region = REG_RAM;
            in_region(phys_page, ROM_BASE, ROM_MASK): region = REG_ROM;
            in_region(phys_page, GFX_BASE, GFX_MASK): region = REG_GFX;
            in_region(phys_page, IO_BASE, IO_MASK):   region = REG_IO;
            default:                                  region = REG_NONE;
        endcase
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus cycle sequencer: mmu enable, chip select, wait states and
// cycle termination by DTACK, VPA (autovector) or BERR.
module m68k_bus_ctrl
    import bus_pkg::*;
#(
    parameter int TRANSLATE_CYCLES = 1,
    parameter int RAM_WAIT         = 0,
    parameter int ROM_WAIT         = 2,
    parameter int IO_TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        as_n,
    input  logic        rw,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [2:0]  fc,
    output logic        mmu_enable,
    input  logic [15:0] phys_page,
    input  logic        dev_ready,
    output logic        ram_cs_n,
    output logic        rom_cs_n,
    output logic        gfx_cs_n,
    output logic        io_cs_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        ub_n,
    output logic        lb_n,
    output logic        dtack_n,
    output logic        berr_n,
    output logic        vpa_n
);

    localparam int WMAX  = (RAM_WAIT > ROM_WAIT) ? RAM_WAIT : ROM_WAIT;
    localparam int WW    = (WMAX < 1) ? 1 : $clog2(WMAX + 1);
    localparam int XW    = $clog2(TRANSLATE_CYCLES + 1);
    localparam int TW    = (IO_TIMEOUT < 1) ? 1 : $clog2(IO_TIMEOUT + 1);

    logic          as_meta;
    logic          as_s;
    state_t        state;
    region_t       region_d;
    region_t       region_q;
    region_t       drv_region;
    logic          rw_q;
    logic          drv_rw;
    logic [XW-1:0] xl_cnt;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    cs_n;
    logic [3:0]    cs_drive;
    logic          is_dev;
    logic          go_ack;
    logic          go_berr;

    phys_decode u_decode (
        .phys_page (phys_page),
        .region    (region_d)
    );

    assign {ram_cs_n, rom_cs_n, gfx_cs_n, io_cs_n} = cs_n;

    // Two-flop synchronizer for the asynchronous CPU address strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_meta <= 1'b1;
            as_s    <= 1'b1;
        end else begin
            as_meta <= as_n;
            as_s    <= as_meta;
        end
    end

    // On the XLATE exit edge the region is not latched yet, so use the
    // live decode; afterwards drive from the latched copy.
    always_comb begin
        drv_region = (state == ST_XLATE) ? region_d : region_q;
        drv_rw     = (state == ST_XLATE) ? rw : rw_q;
        cs_drive   = region_cs(drv_region);
        is_dev     = (region_q == REG_GFX) || (region_q == REG_IO);
        go_ack     = is_dev ? dev_ready : (wait_cnt == '0);
        go_berr    = is_dev && !dev_ready && (tmo_cnt <= TW'(1));
    end

    // Bus cycle FSM; every output is registered for the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            region_q   <= REG_NONE;
            rw_q       <= 1'b1;
            xl_cnt     <= '0;
            wait_cnt   <= '0;
            tmo_cnt    <= '0;
            mmu_enable <= 1'b0;
            cs_n       <= 4'b1111;
            oe_n       <= 1'b1;
            we_n       <= 1'b1;
            ub_n       <= 1'b1;
            lb_n       <= 1'b1;
            dtack_n    <= 1'b1;
            berr_n     <= 1'b1;
            vpa_n      <= 1'b1;
        end else begin
            mmu_enable <= 1'b0;
            cs_n       <= 4'b1111;
            oe_n       <= 1'b1;
            we_n       <= 1'b1;
            ub_n       <= 1'b1;
            lb_n       <= 1'b1;
            dtack_n    <= 1'b1;
            berr_n     <= 1'b1;
            vpa_n      <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (!as_s) begin
                        if (fc == FC_CPU_SPACE) begin
                            state <= ST_AUTOVEC;
                            vpa_n <= 1'b0;
                        end else begin
                            state      <= ST_XLATE;
                            mmu_enable <= 1'b1;
                            xl_cnt     <= XW'(TRANSLATE_CYCLES);
                        end
                    end
                end
                ST_XLATE: begin
                    if (as_s) begin
                        state  <= ST_IDLE;
                        xl_cnt <= '0;
                    end else if (xl_cnt <= XW'(1)) begin
                        xl_cnt   <= '0;
                        region_q <= region_d;
                        rw_q     <= rw;
                        tmo_cnt  <= TW'(IO_TIMEOUT);
                        wait_cnt <= (region_d == REG_ROM) ?
                                    WW'(ROM_WAIT) : WW'(RAM_WAIT);
                        if (region_d == REG_NONE) begin
                            state  <= ST_BERR;
                            berr_n <= 1'b0;
                        end else begin
                            state      <= ST_WAIT;
                            mmu_enable <= 1'b1;
                            cs_n       <= cs_drive;
                            oe_n       <= !drv_rw;
                            we_n       <= drv_rw;
                            ub_n       <= uds_n;
                            lb_n       <= lds_n;
                        end
                    end else begin
                        xl_cnt     <= xl_cnt - XW'(1);
                        mmu_enable <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (as_s) begin
                        state <= ST_IDLE;
                    end else if (go_ack) begin
                        state      <= ST_ACK;
                        mmu_enable <= 1'b1;
                        cs_n       <= cs_drive;
                        oe_n       <= !drv_rw;
                        we_n       <= drv_rw;
                        ub_n       <= uds_n;
                        lb_n       <= lds_n;
                        dtack_n    <= 1'b0;
                    end else if (go_berr) begin
                        state  <= ST_BERR;
                        berr_n <= 1'b0;
                    end else begin
                        mmu_enable <= 1'b1;
                        cs_n       <= cs_drive;
                        oe_n       <= !drv_rw;
                        we_n       <= drv_rw;
                        ub_n       <= uds_n;
                        lb_n       <= lds_n;
                        if (wait_cnt != '0)
                            wait_cnt <= wait_cnt - WW'(1);
                        if (tmo_cnt != '0)
                            tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                ST_ACK: begin
                    if (as_s) begin
                        state <= ST_IDLE;
                    end else begin
                        mmu_enable <= 1'b1;
                        cs_n       <= cs_drive;
                        oe_n       <= !drv_rw;
                        we_n       <= drv_rw;
                        ub_n       <= uds_n;
                        lb_n       <= lds_n;
                        dtack_n    <= 1'b0;
                    end
                end
                ST_BERR: begin
                    if (as_s)
                        state <= ST_IDLE;
                    else
                        berr_n <= 1'b0;
                end
                ST_AUTOVEC: begin
                    if (as_s)
                        state <= ST_IDLE;
                    else
                        vpa_n <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl with default parameters.
// Latencies count clock edges from the first edge that samples as_n low.
module tb_m68k_bus_ctrl;

    localparam int S_DTACK = 0;
    localparam int S_BERR  = 1;
    localparam int S_VPA   = 2;
    localparam int S_IO    = 3;
    localparam int S_MMU   = 4;

    localparam logic [10:0] IDLE_OUTS = 11'b1111_1111_111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        as_n;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
    logic        mmu_enable;
    logic [15:0] phys_page;
    logic        dev_ready;
    logic        ram_cs_n, rom_cs_n, gfx_cs_n, io_cs_n;
    logic        oe_n, we_n, ub_n, lb_n;
    logic        dtack_n, berr_n, vpa_n;
    logic [10:0] outs;

    int   n_vec = 0;
    int   n_bad = 0;
    int   k;
    logic dtack_seen;
    logic mmu_seen;

    always #5 clk = ~clk;

    assign outs = {ram_cs_n, rom_cs_n, gfx_cs_n, io_cs_n,
                   oe_n, we_n, ub_n, lb_n, dtack_n, berr_n, vpa_n};

    m68k_bus_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .as_n       (as_n),
        .rw         (rw),
        .uds_n      (uds_n),
        .lds_n      (lds_n),
        .fc         (fc),
        .mmu_enable (mmu_enable),
        .phys_page  (phys_page),
        .dev_ready  (dev_ready),
        .ram_cs_n   (ram_cs_n),
        .rom_cs_n   (rom_cs_n),
        .gfx_cs_n   (gfx_cs_n),
        .io_cs_n    (io_cs_n),
        .oe_n       (oe_n),
        .we_n       (we_n),
        .ub_n       (ub_n),
        .lb_n       (lb_n),
        .dtack_n    (dtack_n),
        .berr_n     (berr_n),
        .vpa_n      (vpa_n)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic level(input int sel);
        case (sel)
            S_DTACK: return dtack_n;
            S_BERR:  return berr_n;
            S_VPA:   return vpa_n;
            S_IO:    return io_cs_n;
            default: return !mmu_enable;
        endcase
    endfunction

    task automatic wait_low(input string tag, input int sel,
                            input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (!dtack_n) dtack_seen = 1'b1;
            if (mmu_enable) mmu_seen = 1'b1;
        end while (level(sel) && cnt < limit);
        check({tag, "_timeout"}, level(sel), 1'b0);
    endtask

    task automatic start(input logic [2:0] f, input logic [15:0] pg,
                         input logic r, input logic u, input logic l);
        fc        = f;
        phys_page = pg;
        rw        = r;
        uds_n     = u;
        lds_n     = l;
        as_n      = 1'b0;
    endtask

    task automatic end_cycle(input string tag);
        as_n = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_idle"}, outs, IDLE_OUTS);
        check({tag, "_idle_mmu"}, mmu_enable, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        as_n       = 1'b1;
        rw         = 1'b1;
        uds_n      = 1'b1;
        lds_n      = 1'b1;
        fc         = 3'b000;
        phys_page  = 16'h0000;
        dev_ready  = 1'b0;
        dtack_seen = 1'b0;
        mmu_seen   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs, IDLE_OUTS);
        check("reset_mmu", mmu_enable, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // RAM read: 2 sync + 1 translate + 0 wait + 1
        start(3'b101, 16'h8001, 1'b1, 1'b0, 1'b0);
        wait_low("ram", S_DTACK, 40, k);
        check("ram_lat", k - 1, 4);
        check("ram_ack_outs", outs, 11'b0111_0100_011);
        as_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ram_ack_held", dtack_n, 1'b0);
        @(negedge clk);
        check("ram_release", outs, IDLE_OUTS);

        // ROM write, upper byte only: 2 + 1 + 2 + 1
        start(3'b101, 16'h4000, 1'b0, 1'b0, 1'b1);
        wait_low("rom", S_DTACK, 40, k);
        check("rom_lat", k - 1, 6);
        check("rom_ack_outs", outs, 11'b1011_1001_011);
        end_cycle("rom");

        // I/O with ready arriving 10 cycles into the select
        start(3'b101, 16'h0300, 1'b1, 1'b0, 1'b0);
        wait_low("io_sel", S_IO, 40, k);
        repeat (10) @(negedge clk);
        check("io_pre_ready", dtack_n, 1'b1);
        dev_ready = 1'b1;
        @(negedge clk);
        check("io_ready_dtack", dtack_n, 1'b0);
        check("io_ready_berr", berr_n, 1'b1);
        dev_ready = 1'b0;
        end_cycle("io_ready");

        // I/O timeout
        dtack_seen = 1'b0;
        start(3'b101, 16'h03ff, 1'b1, 1'b0, 1'b0);
        wait_low("tmo_sel", S_IO, 40, k);
        wait_low("tmo", S_BERR, 200, k);
        check("tmo_lat", k, 64);
        check("tmo_io_cs", io_cs_n, 1'b1);
        check("tmo_no_dtack", dtack_seen, 1'b0);
        end_cycle("tmo");

        // Ready on the very cycle the timeout expires: ready wins
        start(3'b101, 16'h0300, 1'b1, 1'b0, 1'b0);
        wait_low("tie_sel", S_IO, 40, k);
        repeat (63) @(negedge clk);
        check("tie_pre_berr", berr_n, 1'b1);
        dev_ready = 1'b1;
        @(negedge clk);
        check("tie_dtack", dtack_n, 1'b0);
        check("tie_berr", berr_n, 1'b1);
        dev_ready = 1'b0;
        end_cycle("tie");

        // Unmapped page
        start(3'b101, 16'h1000, 1'b1, 1'b0, 1'b0);
        wait_low("unmap", S_BERR, 40, k);
        check("unmap_lat", k - 1, 3);
        check("unmap_outs", outs, 11'b1111_1111_101);
        end_cycle("unmap");

        // Autovector: no mmu enable, no select
        mmu_seen = 1'b0;
        start(3'b111, 16'h8001, 1'b1, 1'b0, 1'b0);
        wait_low("avec", S_VPA, 40, k);
        check("avec_outs", outs, 11'b1111_1111_110);
        check("avec_no_mmu", mmu_seen, 1'b0);
        end_cycle("avec");

        // Abort during WAIT
        dtack_seen = 1'b0;
        start(3'b101, 16'h0300, 1'b1, 1'b0, 1'b0);
        wait_low("abort_sel", S_IO, 40, k);
        as_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_still_sel", io_cs_n, 1'b0);
        @(negedge clk);
        check("abort_outs", outs, IDLE_OUTS);
        check("abort_mmu", mmu_enable, 1'b0);
        repeat (4) begin
            @(negedge clk);
            if (!dtack_n) dtack_seen = 1'b1;
        end
        check("abort_no_dtack", dtack_seen, 1'b0);

        // Reset pulsed in XLATE
        dtack_seen = 1'b0;
        start(3'b101, 16'h8001, 1'b1, 1'b0, 1'b0);
        wait_low("rst_mmu", S_MMU, 40, k);
        check("rst_xlate_lat", k - 1, 2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_outs", outs, IDLE_OUTS);
        check("rst_mmu", mmu_enable, 1'b0);
        as_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!dtack_n) dtack_seen = 1'b1;
        end
        check("rst_no_dtack", dtack_seen, 1'b0);
        check("rst_after_outs", outs, IDLE_OUTS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
